// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word and streams it to memory.
// Optional immediate range checking is enabled by defining INSTR_ENCODER_RANGE_CHECK_EN.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0,
  parameter int          DEPTH_WORDS  = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          restart,
  input  logic                          src_valid,
  output logic                          src_ready,
  input  logic [6:0]                    src_opcode,
  input  logic [4:0]                    src_rd,
  input  logic [4:0]                    src_rs1,
  input  logic [4:0]                    src_rs2,
  input  logic [2:0]                    src_funct3,
  input  logic [6:0]                    src_funct7,
  input  logic [31:0]                   src_imm,
  output logic                          mem_valid,
  input  logic                          mem_ready,
  output logic [31:0]                   mem_address,
  output logic [3:0]                    mem_wstrobe,
  output logic [31:0]                   mem_wdata,
  output logic [$clog2(DEPTH_WORDS):0]  written,
  output logic                          error
);

  localparam int              CW        = $clog2(DEPTH_WORDS) + 1;
  localparam logic [CW-1:0]   WR_MAX    = CW'(DEPTH_WORDS);
  localparam logic [CW-1:0]   WR_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   WR_ZERO   = {CW{1'b0}};
  localparam logic [31:0]     LAST_ADDR = BASE_ADDRESS + 32'(4 * (DEPTH_WORDS - 1));

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  function automatic logic [31:0] encode(
    input logic [6:0]  opc,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] imm
  );
    logic [31:0] w;
    case (opc)
      OPC_OP:     w = {f7, rs2, rs1, f3, rd, opc};
      OPC_STORE:  w = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
      OPC_BRANCH: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
      OPC_LUI:    w = {imm[31:12], rd, opc};
      OPC_AUIPC:  w = {imm[31:12], rd, opc};
      OPC_JAL:    w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
      default:    w = {imm[11:0], rs1, f3, rd, opc};
    endcase
    return w;
  endfunction

  logic              valid_r;
  logic [31:0]       wdata_r;
  logic [31:0]       addr_r;
  logic [CW-1:0]     written_r;
  logic              valid_n;
  logic [31:0]       wdata_n;
  logic [31:0]       addr_n;
  logic [CW-1:0]     written_n;
  logic              src_ready_s;
  logic              accept_s;
  logic              hs_s;
  logic              load_s;
  logic              ok_s;
  logic [31:0]       enc_s;

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  function automatic logic imm_ok(input logic [6:0] opc, input logic [31:0] imm);
    logic signed [31:0] s;
    logic               ok;
    s = $signed(imm);
    case (opc)
      OPC_OP:     ok = 1'b1;
      OPC_BRANCH: ok = !imm[0] && (s >= -32'sd4096) && (s <= 32'sd4094);
      OPC_JAL:    ok = !imm[0] && (s >= -32'sd1048576) && (s <= 32'sd1048574);
      OPC_LUI:    ok = (imm[11:0] == 12'h000);
      OPC_AUIPC:  ok = (imm[11:0] == 12'h000);
      default:    ok = (s >= -32'sd2048) && (s <= 32'sd2047);
    endcase
    return ok;
  endfunction

  logic error_r;
  assign ok_s  = imm_ok(src_opcode, src_imm);
  assign error = error_r;

  // Sticky range error: only reset clears it, restart leaves it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      error_r <= 1'b0;
    end else if (accept_s && !ok_s) begin
      error_r <= 1'b1;
    end else begin
      error_r <= error_r;
    end
  end
`else
  assign ok_s  = 1'b1;
  assign error = 1'b0;
`endif

  assign enc_s       = encode(src_opcode, src_rd, src_rs1, src_rs2, src_funct3, src_funct7, src_imm);
  assign src_ready_s = !valid_r || mem_ready;
  assign src_ready   = src_ready_s;
  assign mem_valid   = valid_r;
  assign mem_wdata   = wdata_r;
  assign mem_address = addr_r;
  assign mem_wstrobe = 4'b1111;
  assign written     = written_r;

  // Next-state: output slot, write pointer and written counter.
  always_comb begin
    accept_s  = src_valid && src_ready_s;
    hs_s      = valid_r && mem_ready;
    load_s    = accept_s && ok_s;
    valid_n   = valid_r;
    wdata_n   = wdata_r;
    addr_n    = addr_r;
    written_n = written_r;

    if (load_s) begin
      valid_n = 1'b1;
      wdata_n = enc_s;
    end else if (hs_s) begin
      valid_n = 1'b0;
    end else begin
      valid_n = valid_r;
    end

    // The output address is the pointer itself, so a word held across restart lands at BASE_ADDRESS.
    if (restart) begin
      addr_n    = BASE_ADDRESS;
      written_n = WR_ZERO;
    end else if (hs_s) begin
      addr_n    = (addr_r == LAST_ADDR) ? BASE_ADDRESS : addr_r + 32'd4;
      written_n = (written_r == WR_MAX) ? written_r : written_r + WR_ONE;
    end else begin
      addr_n    = addr_r;
      written_n = written_r;
    end
  end

  // State register with synchronous reset; a pending word is dropped on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r   <= 1'b0;
      wdata_r   <= 32'h0000_0000;
      addr_r    <= BASE_ADDRESS;
      written_r <= WR_ZERO;
    end else begin
      valid_r   <= valid_n;
      wdata_r   <= wdata_n;
      addr_r    <= addr_n;
      written_r <= written_n;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized traffic
// compared against a behavioural model of the encoding and memory-side bookkeeping.
module tb_instr_encoder;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 4;

  localparam logic [6:0] OP     = 7'h33;
  localparam logic [6:0] OPIMM  = 7'h13;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] BRANCH = 7'h63;
  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] AUIPC  = 7'h17;
  localparam logic [6:0] JAL    = 7'h6F;

  logic        clk = 1'b0;
  logic        reset, restart, src_valid, src_ready, mem_valid, mem_ready, error;
  logic [6:0]  src_opcode, src_funct7;
  logic [4:0]  src_rd, src_rs1, src_rs2;
  logic [2:0]  src_funct3;
  logic [31:0] src_imm, mem_address, mem_wdata;
  logic [3:0]  mem_wstrobe;
  logic [2:0]  written;

  always #5 clk = ~clk;

  instr_encoder #(.BASE_ADDRESS(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .reset(reset), .restart(restart),
    .src_valid(src_valid), .src_ready(src_ready), .src_opcode(src_opcode),
    .src_rd(src_rd), .src_rs1(src_rs1), .src_rs2(src_rs2),
    .src_funct3(src_funct3), .src_funct7(src_funct7), .src_imm(src_imm),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_address(mem_address),
    .mem_wstrobe(mem_wstrobe), .mem_wdata(mem_wdata),
    .written(written), .error(error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: word index of the write pointer, words written, pending output word, sticky error.
  int          m_ptr;
  int          m_written;
  bit          m_pend;
  bit          m_err;
  logic [31:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference encoding built by arithmetic field placement from the instruction formats.
  function automatic logic [31:0] ref_enc(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                                          input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [31:0] imm);
    int unsigned u, o, r, a, b, c, f;
    u = imm; o = op; r = rd; a = rs1; b = rs2; c = f3; f = f7;
    if (op == OP)
      return (f << 25) | (b << 20) | (a << 15) | (c << 12) | (r << 7) | o;
    else if (op == STORE)
      return (((u >> 5) & 127) << 25) | (b << 20) | (a << 15) | (c << 12) | ((u & 31) << 7) | o;
    else if (op == BRANCH)
      return (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (b << 20) | (a << 15) |
             (c << 12) | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | o;
    else if (op == LUI || op == AUIPC)
      return (u & 32'hFFFF_F000) | (r << 7) | o;
    else if (op == JAL)
      return (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) | (((u >> 11) & 1) << 20) |
             (((u >> 12) & 255) << 12) | (r << 7) | o;
    else
      return ((u & 4095) << 20) | (a << 15) | (c << 12) | (r << 7) | o;
  endfunction

  function automatic bit imm_bad(input logic [6:0] op, input logic [31:0] imm);
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    int s;
    s = imm;
    if (op == OP) return 1'b0;
    if (op == LUI || op == AUIPC) return (imm & 32'h0000_0FFF) != 32'h0;
    if (op == BRANCH) return (s % 2 != 0) || s < -4096 || s > 4094;
    if (op == JAL) return (s % 2 != 0) || s < -1048576 || s > 1048574;
    return s < -2048 || s > 2047;
`else
    return 1'b0;
`endif
  endfunction

  // One clock cycle: apply inputs, compare outputs against the model, advance the model past the edge.
  task automatic cycle(input bit sv, input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                       input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                       input bit mr, input bit rs);
    bit exp_rdy, hs, acc, bad;
    src_valid = sv; src_opcode = op; src_rd = rd; src_rs1 = rs1; src_rs2 = rs2;
    src_funct3 = f3; src_funct7 = f7; src_imm = imm; mem_ready = mr; restart = rs;
    #1;
    exp_rdy = !m_pend || mr;
    chk("src_ready", 32'(src_ready), 32'(exp_rdy));
    chk("mem_valid", 32'(mem_valid), 32'(m_pend));
    chk("written", 32'(written), 32'(m_written));
    chk("error", 32'(error), 32'(m_err));
    if (m_pend) begin
      chk("mem_address", mem_address, BASE + 32'(4 * m_ptr));
      chk("mem_wdata", mem_wdata, m_data);
      chk("mem_wstrobe", 32'(mem_wstrobe), 32'hF);
    end
    hs  = m_pend && mr;
    acc = sv && exp_rdy;
    bad = imm_bad(op, imm);
    @(posedge clk);
    #1;
    if (rs) begin
      m_ptr = 0; m_written = 0;
    end else if (hs) begin
      m_ptr = (m_ptr + 1) % DEPTH;
      if (m_written < DEPTH) m_written++;
    end
    if (acc && !bad) begin
      m_pend = 1'b1; m_data = ref_enc(op, rd, rs1, rs2, f3, f7, imm);
    end else if (hs) begin
      m_pend = 1'b0;
    end
    if (acc && bad) m_err = 1'b1;
  endtask

  task automatic idle(input bit mr, input bit rs);
    cycle(1'b0, OPIMM, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, mr, rs);
  endtask

  task automatic do_reset();
    reset = 1'b1; restart = 1'b0; src_valid = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_ptr = 0; m_written = 0; m_pend = 1'b0; m_err = 1'b0; m_data = 32'h0;
    chk("rst_valid", 32'(mem_valid), 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_address", mem_address, BASE);
    chk("rst_written", 32'(written), 32'h0);
    chk("rst_error", 32'(error), 32'h0);
    chk("rst_src_ready", 32'(src_ready), 32'h1);
  endtask

  initial begin
    logic [6:0]  ops [8];
    logic [31:0] rimm, rv;
    ops = '{OP, OPIMM, STORE, BRANCH, LUI, AUIPC, JAL, 7'h03};
    reset = 1'b1; restart = 1'b0; src_valid = 1'b0; mem_ready = 1'b0;
    src_opcode = 7'd0; src_rd = 5'd0; src_rs1 = 5'd0; src_rs2 = 5'd0;
    src_funct3 = 3'd0; src_funct7 = 7'd0; src_imm = 32'd0;
    do_reset();

    // addi x1,x0,5 with garbage funct7/rs2 that must not leak into the word
    cycle(1'b1, OPIMM, 5'd1, 5'd0, 5'd17, 3'd0, 7'h55, 32'd5, 1'b1, 1'b0);
    chk("addi_word", mem_wdata, 32'h0050_0093);
    chk("addi_addr", mem_address, BASE);
    idle(1'b1, 1'b0);

    // Back-to-back sw / sub / beq from a fresh pointer
    idle(1'b1, 1'b1);
    cycle(1'b1, STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b1, 1'b0);
    chk("sw_word", mem_wdata, 32'h0020_A423);
    chk("sw_addr", mem_address, BASE);
    cycle(1'b1, OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0, 1'b1, 1'b0);
    chk("sub_word", mem_wdata, 32'h4020_81B3);
    chk("sub_addr", mem_address, BASE + 32'd4);
    cycle(1'b1, BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4, 1'b1, 1'b0);
    chk("beq_word", mem_wdata, 32'hFE20_8EE3);
    chk("beq_addr", mem_address, BASE + 32'd8);
    idle(1'b1, 1'b0);

    // jal x1,2048 stalled for three cycles
    idle(1'b1, 1'b1);
    cycle(1'b1, JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("jal_hold_word", mem_wdata, 32'h0010_00EF);
      idle(1'b0, 1'b0);
      chk("jal_stall_ready", 32'(src_ready), 32'h0);
    end
    idle(1'b1, 1'b0);
    chk("jal_written", 32'(written), 32'h1);
    chk("jal_drained", 32'(mem_valid), 32'h0);

    // Restart while a word is stalled moves it to BASE
    cycle(1'b1, OPIMM, 5'd4, 5'd4, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0, 1'b0);
    chk("stall_addr", mem_address, BASE + 32'd4);
    idle(1'b0, 1'b1);
    chk("restart_pending_addr", mem_address, BASE);
    idle(1'b1, 1'b0);

    // DEPTH=4: five writes wrap, written saturates; restart beats a simultaneous handshake
    idle(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, OPIMM, 5'(i), 5'd2, 5'd0, 3'd0, 7'd0, 32'(i), 1'b1, 1'b0);
    chk("wrap_addr5", mem_address, BASE);
    idle(1'b1, 1'b0);
    chk("written_sat", 32'(written), 32'd4);
    cycle(1'b1, OPIMM, 5'd9, 5'd9, 5'd0, 3'd0, 7'd0, 32'd9, 1'b1, 1'b0);
    idle(1'b1, 1'b1);
    chk("restart_written", 32'(written), 32'd0);
    chk("restart_addr", mem_address, BASE);

    // Misaligned branch offset followed by lui x5,0x12345
    idle(1'b1, 1'b1);
    cycle(1'b1, BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 1'b1, 1'b0);
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    chk("range_no_write", 32'(mem_valid), 32'h0);
    chk("range_error", 32'(error), 32'h1);
`else
    chk("trunc_write", 32'(mem_valid), 32'h1);
    chk("trunc_error", 32'(error), 32'h0);
`endif
    cycle(1'b1, LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b1, 1'b0);
    chk("lui_word", mem_wdata, 32'h1234_52B7);
    idle(1'b1, 1'b0);

    // Reset mid-transfer discards the stalled word
    cycle(1'b1, OPIMM, 5'd7, 5'd7, 5'd0, 3'd0, 7'd0, 32'd7, 1'b0, 1'b0);
    do_reset();
    idle(1'b1, 1'b0);
    chk("reset_discard_written", 32'(written), 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: rimm = $urandom;
        1: rimm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: begin rv = $urandom; rimm = rv & 32'hFFFF_F000; end
        default: rimm = 32'($urandom_range(0, 2097151)) - 32'd1048576;
      endcase
      cycle(($urandom_range(0, 9) < 7), ops[$urandom_range(0, 7)], 5'($urandom), 5'($urandom),
            5'($urandom), 3'($urandom), 7'($urandom), rimm,
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 29) == 0));
    end
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
